// File: rtl/parking_exit_ctrl.sv
// Exit gate controller: two-digit exit code, bounded gate opening, lot occupancy count.
// Optional EXIT_LOCKOUT_EN adds the wrong-code try counter and the LOCKOUT state.
module parking_exit_ctrl #(
    parameter int unsigned CAPACITY     = 8,
    parameter int unsigned CNT_W        = 4,
    parameter logic [3:0]  EXIT_CODE    = 4'b1001,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned GATE_TIMEOUT = 16,
    parameter int unsigned TMO_W        = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exit_sensor,
    input  logic             gate_clear,
    input  logic             key_valid,
    input  logic [1:0]       key_digit,
    input  logic             car_in,
    input  logic             admin_clear,
    output logic             gate_open,
    output logic             green_led,
    output logic             red_led,
    output logic             alarm,
    output logic [CNT_W-1:0] occupancy,
    output logic             lot_full,
    output logic             lot_empty,
    output logic [2:0]       state_dbg
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    if (((1 << CNT_W) <= CAPACITY) || ((1 << TMO_W) <= GATE_TIMEOUT) || (MAX_TRIES < 1))
    begin : g_bad_params
        $error("parking_exit_ctrl: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CODE1   = 3'd1,
        CODE2   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         digit, digit_nxt;
    logic [TMO_W-1:0]   timer, timer_nxt;
    logic [CNT_W-1:0]   occ_nxt;
    logic               dec;
`ifdef EXIT_LOCKOUT_EN
    logic [TRY_W-1:0]   tries, tries_nxt;
`else
    logic               unused_admin_clear;
    assign unused_admin_clear = admin_clear;
`endif

    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        timer_nxt = timer;
        dec       = 1'b0;
`ifdef EXIT_LOCKOUT_EN
        tries_nxt = tries;
`endif
        case (state)
            IDLE: if (exit_sensor && occupancy != '0) state_nxt = CODE1;
            CODE1: begin
                // Abort has priority over a keypad digit in the same cycle.
                if (!exit_sensor) state_nxt = IDLE;
                else if (key_valid) begin
                    digit_nxt = key_digit;
                    state_nxt = CODE2;
                end
            end
            CODE2: begin
                if (!exit_sensor) state_nxt = IDLE;
                else if (key_valid) begin
                    if ({digit, key_digit} == EXIT_CODE) begin
                        timer_nxt = '0;
                        state_nxt = OPEN;
`ifdef EXIT_LOCKOUT_EN
                        tries_nxt = '0;
`endif
                    end else begin
                        state_nxt = CODE1;
`ifdef EXIT_LOCKOUT_EN
                        tries_nxt = tries + 1'b1;
                        if (tries == TRY_W'(MAX_TRIES - 1)) state_nxt = LOCKOUT;
`endif
                    end
                end
            end
            OPEN: begin
                timer_nxt = timer + 1'b1;
                if (gate_clear) begin
                    dec       = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == TMO_W'(GATE_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end
            end
            LOCKOUT: begin
`ifdef EXIT_LOCKOUT_EN
                if (admin_clear) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
`ifdef EXIT_LOCKOUT_EN
        if (admin_clear) tries_nxt = '0;
`endif
    end

    // A simultaneous entry and exit cancel out, even when the lot is full.
    always_comb begin
        occ_nxt = occupancy;
        if (car_in && !dec) begin
            if (occupancy != CNT_W'(CAPACITY)) occ_nxt = occupancy + 1'b1;
        end else if (dec && !car_in) begin
            occ_nxt = occupancy - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            digit     <= '0;
            timer     <= '0;
            occupancy <= '0;
            lot_full  <= 1'b0;
            lot_empty <= 1'b1;
            gate_open <= 1'b0;
            green_led <= 1'b0;
            red_led   <= 1'b0;
`ifdef EXIT_LOCKOUT_EN
            tries     <= '0;
            alarm     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            digit     <= digit_nxt;
            timer     <= timer_nxt;
            occupancy <= occ_nxt;
            lot_full  <= (occ_nxt == CNT_W'(CAPACITY));
            lot_empty <= (occ_nxt == '0);
            gate_open <= (state_nxt == OPEN);
            green_led <= (state_nxt == OPEN);
`ifdef EXIT_LOCKOUT_EN
            tries     <= tries_nxt;
            alarm     <= (state_nxt == LOCKOUT);
`endif
            case (state_nxt)
                CODE1, CODE2: red_led <= 1'b1;
                LOCKOUT:      red_led <= (state == LOCKOUT) ? ~red_led : 1'b1;
                default:      red_led <= 1'b0;
            endcase
        end
    end

`ifndef EXIT_LOCKOUT_EN
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_parking_exit_ctrl.sv
// Scoreboard bench for parking_exit_ctrl: cycle-level reference model feeds an expected
// queue of output vectors; a monitor pops and compares one vector per clock edge.
module tb_parking_exit_ctrl;

    localparam int          CAPACITY     = 8;
    localparam int          CNT_W        = 4;
    localparam logic [3:0]  EXIT_CODE    = 4'b1001;
    localparam int          MAX_TRIES    = 3;
    localparam int          GATE_TIMEOUT = 16;
    localparam int          TMO_W        = 5;
    localparam int          OW           = 6 + CNT_W;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic             exit_sensor = 1'b0;
    logic             gate_clear  = 1'b0;
    logic             key_valid   = 1'b0;
    logic [1:0]       key_digit   = 2'b00;
    logic             car_in      = 1'b0;
    logic             admin_clear = 1'b0;
    logic             gate_open, green_led, red_led, alarm, lot_full, lot_empty;
    logic [CNT_W-1:0] occupancy;
    logic [2:0]       state_dbg;

    parking_exit_ctrl #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .EXIT_CODE(EXIT_CODE),
        .MAX_TRIES(MAX_TRIES), .GATE_TIMEOUT(GATE_TIMEOUT), .TMO_W(TMO_W)
    ) dut (
        .clock(clock), .reset(reset), .exit_sensor(exit_sensor), .gate_clear(gate_clear),
        .key_valid(key_valid), .key_digit(key_digit), .car_in(car_in),
        .admin_clear(admin_clear), .gate_open(gate_open), .green_led(green_led),
        .red_led(red_led), .alarm(alarm), .occupancy(occupancy), .lot_full(lot_full),
        .lot_empty(lot_empty), .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    // Reference model: what the driver at the exit is doing, in plain terms.
    typedef enum int {M_IDLE, M_KEY1, M_KEY2, M_GATE, M_LOCK} mphase_t;
    mphase_t    ph;
    int         occ, tries, open_cycles;
    logic [1:0] first_digit;
    logic       lock_red;
    logic [1:0] code_hi, code_lo;

    function automatic logic [OW-1:0] dut_vec();
        return {gate_open, green_led, red_led, alarm, occupancy, lot_full, lot_empty};
    endfunction

    function automatic logic [OW-1:0] model_vec();
        logic g, r, a;
        g = (ph == M_GATE);
        r = (ph == M_KEY1) || (ph == M_KEY2) || ((ph == M_LOCK) && lock_red);
        a = (ph == M_LOCK);
        return {g, g, r, a, CNT_W'(occ), (occ == CAPACITY), (occ == 0)};
    endfunction

    task automatic model_reset();
        ph = M_IDLE; occ = 0; tries = 0; open_cycles = 0;
        first_digit = 2'b00; lock_red = 1'b0;
    endtask

    task automatic model_step(input logic es, input logic gc, input logic kv,
                              input logic [1:0] kd, input logic ci, input logic ac);
        mphase_t nph;
        bit      left_by_clear;
        int      nocc;
        nph = ph;
        left_by_clear = (ph == M_GATE) && gc;
        nocc = occ;
        if (ci && left_by_clear) nocc = occ;
        else if (ci) nocc = (occ < CAPACITY) ? occ + 1 : occ;
        else if (left_by_clear) nocc = occ - 1;
        case (ph)
            M_IDLE: if (es && occ > 0) nph = M_KEY1;
            M_KEY1: begin
                if (!es) nph = M_IDLE;
                else if (kv) begin first_digit = kd; nph = M_KEY2; end
            end
            M_KEY2: begin
                if (!es) nph = M_IDLE;
                else if (kv) begin
                    if ({first_digit, kd} == EXIT_CODE) begin
                        tries = 0; open_cycles = 0; nph = M_GATE;
                    end else begin
                        nph = M_KEY1;
`ifdef EXIT_LOCKOUT_EN
                        tries = tries + 1;
                        if (tries >= MAX_TRIES) nph = M_LOCK;
`endif
                    end
                end
            end
            M_GATE: begin
                open_cycles = open_cycles + 1;
                if (gc || open_cycles >= GATE_TIMEOUT) nph = M_IDLE;
            end
            M_LOCK: begin
`ifdef EXIT_LOCKOUT_EN
                if (ac) nph = M_IDLE;
`endif
            end
            default: nph = M_IDLE;
        endcase
`ifdef EXIT_LOCKOUT_EN
        if (ac) tries = 0;
`endif
        if (nph == M_LOCK) lock_red = (ph == M_LOCK) ? !lock_red : 1'b1;
        ph  = nph;
        occ = nocc;
    endtask

    // driver tasks
    task automatic step(input logic es, input logic gc, input logic kv,
                        input logic [1:0] kd, input logic ci, input logic ac);
        @(negedge clock);
        exit_sensor = es; gate_clear = gc; key_valid = kv;
        key_digit = kd; car_in = ci; admin_clear = ac;
        model_step(es, gc, kv, kd, ci, ac);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle(input logic es, input int n);
        for (int i = 0; i < n; i++) step(es, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [1:0] a, input logic [1:0] b);
        step(1'b1, 1'b0, 1'b1, a, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        logic [OW-1:0] rv;
        @(negedge clock);
        #2;
        reset = 1'b0;
        exit_sensor = 1'b0; gate_clear = 1'b0; key_valid = 1'b0;
        key_digit = 2'b00; car_in = 1'b0; admin_clear = 1'b0;
        model_reset();
        rv = {4'b0000, CNT_W'(0), 1'b0, 1'b1};
        #1;
        checks++;
        if (dut_vec() !== rv) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", dut_vec(), rv);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    // scoreboard monitor
    initial begin
        logic [OW-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dut_vec() !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got gate/green/red/alarm=%b occ=%0d full/empty=%b expected gate/green/red/alarm=%b occ=%0d full/empty=%b",
                             $time, dut_vec()[OW-1 -: 4], dut_vec()[CNT_W+1:2], dut_vec()[1:0],
                             e[OW-1 -: 4], e[CNT_W+1:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [3:0]  code_tmp;
        logic        es, kv, ci, gc, ac;
        logic [1:0]  kd;
        code_tmp = EXIT_CODE;
        code_hi  = code_tmp[3:2];
        code_lo  = code_tmp[1:0];
        model_reset();
        do_reset();

        // three entries, then a valid exit cleared after five open cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 1);
        enter_code(2'b10, 2'b01);
        idle(1'b0, 4);
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        idle(1'b0, 2);

        // gate timeout with no clear
        idle(1'b1, 1);
        enter_code(code_hi, code_lo);
        idle(1'b0, 20);

        // three wrong codes, lockout toggling, attendant release
        idle(1'b1, 1);
        for (int i = 0; i < 3; i++) enter_code(2'b00, 2'b00);
        idle(1'b1, 5);
        step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
        idle(1'b0, 2);

        // abort in CODE2 keeps the try count; two more misses then lock
        idle(1'b1, 1);
        enter_code(2'b11, 2'b11);
        step(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        idle(1'b1, 1);
        enter_code(2'b01, 2'b10);
        enter_code(2'b00, 2'b11);
        idle(1'b1, 3);
        step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);

        // abort wins over a digit in CODE1; car_in coincident with gate_clear
        idle(1'b1, 1);
        step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
        idle(1'b1, 1);
        enter_code(code_hi, code_lo);
        idle(1'b0, 2);
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);

        // saturation, then full-lot car_in alongside a gate_clear
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(1'b1, 1);
        enter_code(code_hi, code_lo);
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(1'b0, 1);

        // reset mid-code, then a phantom car on an empty lot
        idle(1'b1, 2);
        do_reset();
        idle(1'b1, 4);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(1'b1, 2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            es = ($urandom_range(0, 9) != 0);
            kv = ($urandom_range(0, 2) == 0);
            ci = ($urandom_range(0, 7) == 0);
            gc = ($urandom_range(0, 5) == 0);
            ac = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) kd = (ph == M_KEY1) ? code_hi : code_lo;
            else kd = 2'($urandom_range(0, 3));
            step(es, gc, kv, kd, ci, ac);
        end
        idle(1'b0, 1);

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
